local_port_in_fifo: RTL and testbench

Router local-port ingress stage for the 4-core mesh. Sits directly downstream of the CPU-side flit packer: it accepts 37-bit flits `{data[31:0], last, dest[3:0]}` over the Outw/Inr handshake and buffers them in a small FIFO. At enqueue it computes the XY output direction for each flit, then presents the head flit with a one-hot port request to the router crossbar arbiter.

---
 rtl/local_port_in_fifo.sv | 122 ++++++++++++
 tb/tb_local_port_in_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_port_in_fifo.sv
// Local-port ingress FIFO for the 4-core mesh router: buffers CPU flits, computes the
// XY output direction at enqueue and presents the head flit with a one-hot port request.
module local_port_in_fifo #(
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH      = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   dataInL,
    input  logic                    Outw,
    output logic                    Inr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic [4:0]              out_req,
    input  logic                    out_grant,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_bad_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic MY_X_B = 1'(MY_X);
    localparam logic MY_Y_B = 1'(MY_Y);

    localparam logic [4:0] REQ_L = 5'b00001;
    localparam logic [4:0] REQ_N = 5'b00010;
    localparam logic [4:0] REQ_E = 5'b00100;
    localparam logic [4:0] REQ_S = 5'b01000;
    localparam logic [4:0] REQ_W = 5'b10000;

    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [4:0]            route_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [3:0] dest;
    logic       dest_ok;
    logic       full;
    logic       empty;
    logic       accept;
    logic       wr_en;
    logic       rd_en;
    logic [4:0] route;

    assign dest    = dataInL[3:0];
    assign dest_ok = (dest[3:2] == 2'b00);
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

    // Ready depends only on registered occupancy; a grant frees a slot one cycle later.
    assign Inr    = !full && !reset;
    assign accept = Outw && Inr;
    assign wr_en  = accept && dest_ok;
    assign rd_en  = !empty && out_grant;

    // XY routing: resolve column first, then row; y grows southward.
    always_comb begin
        route = REQ_L;
        if (dest[0] > MY_X_B) begin
            route = REQ_E;
        end else if (dest[0] < MY_X_B) begin
            route = REQ_W;
        end else if (dest[1] > MY_Y_B) begin
            route = REQ_S;
        end else if (dest[1] < MY_Y_B) begin
            route = REQ_N;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (accept && !dest_ok);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: empty gates every output that reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem_q[wr_ptr_q]  <= dataInL;
            route_mem_q[wr_ptr_q] <= route;
        end
    end

    assign out_valid    = !empty;
    assign out_data     = empty ? '0 : data_mem_q[rd_ptr_q];
    assign out_req      = empty ? 5'b00000 : route_mem_q[rd_ptr_q];
    assign count        = count_q;
    assign err_bad_dest = err_q;

endmodule

// File: tb/tb_local_port_in_fifo.sv
// Bench for local_port_in_fifo: two instances (router 0,0 and 1,1) share stimulus so
// both routing tables are checked on every flit.
module tb_local_port_in_fifo;

  localparam int DW    = 37;
  localparam int DEPTH = 4;
  localparam int EW    = DW + 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] dataInL;
  logic          Outw;
  logic          out_grant;

  logic          Inr, out_valid, err_bad_dest;
  logic [DW-1:0] out_data;
  logic [4:0]    out_req;
  logic [2:0]    count;

  logic          Inr1, out_valid1, err_bad_dest1;
  logic [DW-1:0] out_data1;
  logic [4:0]    out_req1;
  logic [2:0]    count1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  local_port_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MY_X(0), .MY_Y(0)) dut0 (
    .clk(clk), .reset(reset), .dataInL(dataInL), .Outw(Outw), .Inr(Inr),
    .out_data(out_data), .out_valid(out_valid), .out_req(out_req),
    .out_grant(out_grant), .count(count), .err_bad_dest(err_bad_dest)
  );

  local_port_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MY_X(1), .MY_Y(1)) dut1 (
    .clk(clk), .reset(reset), .dataInL(dataInL), .Outw(Outw), .Inr(Inr1),
    .out_data(out_data1), .out_valid(out_valid1), .out_req(out_req1),
    .out_grant(out_grant), .count(count1), .err_bad_dest(err_bad_dest1)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] pay, input logic last,
                                       input logic [3:0] dest);
    return {pay, last, dest};
  endfunction

  // XY rule straight from the routing description: column first, then row
  function automatic logic [4:0] exp_route(input logic [3:0] dest, input int mx, input int my);
    int x, y;
    x = int'(dest[0]);
    y = int'(dest[1]);
    if (x > mx) return 5'b00100;
    if (x < mx) return 5'b10000;
    if (y > my) return 5'b01000;
    if (y < my) return 5'b00010;
    return 5'b00001;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Outw = 1'b0;
    out_grant = 1'b0;
    dataInL = '0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] pay;
    logic        last;
    logic [4:0]  req00;
    logic [4:0]  req11;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic err_m;
    int   pay_k;

    tbl[0] = '{4'h0, 32'hDEADBEEF, 1'b1, 5'b00001, 5'b10000};
    tbl[1] = '{4'h1, 32'h11111111, 1'b0, 5'b00100, 5'b00010};
    tbl[2] = '{4'h2, 32'h22222222, 1'b1, 5'b01000, 5'b10000};
    tbl[3] = '{4'h3, 32'h33333333, 1'b0, 5'b00100, 5'b00001};
    tbl[4] = '{4'h0, 32'hA5A5A5A5, 1'b0, 5'b00001, 5'b10000};

    // reset values
    reset = 1'b1;
    Outw = 1'b0;
    out_grant = 1'b0;
    dataInL = '0;
    tick();
    chk("rst_inr", Inr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_req", out_req, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err_bad_dest, 0);
    reset = 1'b0;
    tick();
    chk("rel_inr", Inr, 1);

    // table: single flit through, route on both routers, then grant drains it
    for (int i = 0; i < 5; i++) begin
      dataInL = mk(tbl[i].pay, tbl[i].last, tbl[i].dest);
      Outw = 1'b1;
      tick();
      Outw = 1'b0;
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_data", i), out_data, mk(tbl[i].pay, tbl[i].last, tbl[i].dest));
      chk($sformatf("tbl%0d_req00", i), out_req, tbl[i].req00);
      chk($sformatf("tbl%0d_req11", i), out_req1, tbl[i].req11);
      out_grant = 1'b1;
      tick();
      out_grant = 1'b0;
      chk($sformatf("tbl%0d_empty", i), out_valid, 0);
      chk($sformatf("tbl%0d_count", i), count, 0);
    end

    // fill, blocked write, grant frees slot next cycle, drain order
    for (int i = 1; i <= 4; i++) begin
      dataInL = mk(32'(i), 1'b0, 4'h0);
      Outw = 1'b1;
      tick();
    end
    chk("fill_count", count, 4);
    chk("fill_inr", Inr, 0);
    dataInL = mk(32'd5, 1'b1, 4'h0);
    tick();
    chk("fill_blocked_count", count, 4);
    chk("fill_head_hold", out_data, mk(32'd1, 1'b0, 4'h0));
    out_grant = 1'b1;
    chk("full_grant_inr", Inr, 0);
    tick();
    out_grant = 1'b0;
    chk("free_inr", Inr, 1);
    chk("free_count", count, 3);
    tick();
    Outw = 1'b0;
    chk("refill_count", count, 4);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("drain%0d", i), out_data, mk(32'(i), (i == 5), 4'h0));
      out_grant = 1'b1;
      tick();
    end
    out_grant = 1'b0;
    chk("drain_empty", out_valid, 0);

    // streaming: write and grant every cycle
    Outw = 1'b1;
    out_grant = 1'b1;
    for (int k = 0; k < 20; k++) begin
      dataInL = mk(32'(k), 1'b0, 4'h2);
      tick();
      chk($sformatf("stream%0d_count", k), count, 1);
      chk($sformatf("stream%0d_head", k), out_data, mk(32'(k), 1'b0, 4'h2));
    end
    Outw = 1'b0;
    tick();
    out_grant = 1'b0;
    chk("stream_end_valid", out_valid, 0);

    // bad destination: handshaken, dropped, sticky error
    dataInL = mk(32'hBAD0BAD0, 1'b0, 4'h4);
    Outw = 1'b1;
    chk("bad_inr", Inr, 1);
    tick();
    Outw = 1'b0;
    chk("bad_count", count, 0);
    chk("bad_valid", out_valid, 0);
    chk("bad_err", err_bad_dest, 1);
    dataInL = mk(32'h600D600D, 1'b1, 4'h1);
    Outw = 1'b1;
    tick();
    Outw = 1'b0;
    out_grant = 1'b1;
    tick();
    out_grant = 1'b0;
    chk("bad_err_sticky", err_bad_dest, 1);
    chk("bad_after_count", count, 0);

    // reset mid-stream with three flits buffered
    for (int i = 0; i < 3; i++) begin
      dataInL = mk(32'h100 + 32'(i), 1'b0, 4'h0);
      Outw = 1'b1;
      tick();
    end
    chk("pre_rst_count", count, 3);
    dataInL = mk(32'h999, 1'b0, 4'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_inr", Inr, 0);
    chk("mid_rst_err", err_bad_dest, 0);
    tick();
    chk("rst_write_lost", count, 0);
    reset = 1'b0;
    dataInL = mk(32'h777, 1'b1, 4'h3);
    tick();
    Outw = 1'b0;
    chk("post_rst_data", out_data, mk(32'h777, 1'b1, 4'h3));
    chk("post_rst_count", count, 1);
    out_grant = 1'b1;
    tick();
    out_grant = 1'b0;

    // randomized traffic against a queue model
    exp_q.delete();
    err_m = 1'b0;
    pay_k = 0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  d;
      logic        can_w;
      logic [DW-1:0] f;
      d = ($urandom_range(0, 15) == 0) ? 4'(4 + $urandom_range(0, 11)) : 4'($urandom_range(0, 3));
      f = mk($urandom, 1'($urandom_range(0, 1)), d);
      dataInL = f;
      Outw = 1'($urandom_range(0, 99) < 60);
      out_grant = 1'($urandom_range(0, 99) < 50);
      #1;
      can_w = (exp_q.size() < DEPTH);
      chk("rnd_inr", Inr, can_w);
      chk("rnd_valid", out_valid, exp_q.size() > 0);
      chk("rnd_count", count, exp_q.size());
      chk("rnd_err", err_bad_dest, err_m);
      if (exp_q.size() > 0) begin
        chk("rnd_data", out_data, exp_q[0][DW-1:0]);
        chk("rnd_req00", out_req, exp_q[0][DW+4:DW]);
        chk("rnd_req11", out_req1, exp_q[0][DW+9:DW+5]);
      end else begin
        chk("rnd_req_idle", out_req, 0);
      end
      if (out_grant && exp_q.size() > 0) void'(exp_q.pop_front());
      if (Outw && can_w) begin
        if (d[3:2] != 2'b00) err_m = 1'b1;
        else exp_q.push_back({exp_route(d, 1, 1), exp_route(d, 0, 0), f});
        pay_k++;
      end
      @(posedge clk);
      #1;
    end
    Outw = 1'b0;
    out_grant = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
